// File: rtl/pdm_cic_decimator.sv
// Stereo PDM front end: captures L on micclk falling and R on micclk rising edges,
// then decimates each channel through a 3rd-order CIC by 2^LOG2_DEC with valid/ready output.
module pdm_cic_decimator #(
   parameter int LOG2_DEC = 5,
   parameter int CIC_W    = 3*LOG2_DEC+2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             micclk,
   input  logic             pdm_data,
   output logic [CIC_W-1:0] pcm_left,
   output logic [CIC_W-1:0] pcm_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   localparam logic [LOG2_DEC-1:0] DCNT_LAST = {LOG2_DEC{1'b1}};

   function automatic logic signed [CIC_W-1:0] pdm_to_x(input logic bit_in);
      logic signed [CIC_W-1:0] x;
      if (bit_in)
         x = {{(CIC_W-1){1'b0}}, 1'b1};
      else
         x = {CIC_W{1'b1}};
      return x;
   endfunction

   logic                    pdm_m;
   logic                    pdm_s;
   logic                    mc_d;
   logic                    rise;
   logic                    fall;
   logic                    strobe_p0;
   logic signed [CIC_W-1:0] x_p0;
   logic [LOG2_DEC-1:0]     dcnt;

   logic signed [CIC_W-1:0] l_i1_p0;
   logic signed [CIC_W-1:0] l_i2_p0;
   logic signed [CIC_W-1:0] l_i3_p0;
   logic signed [CIC_W-1:0] r_i1_p0;
   logic signed [CIC_W-1:0] r_i2_p0;
   logic signed [CIC_W-1:0] r_i3_p0;

   logic                    vld_p1;
   logic signed [CIC_W-1:0] l_d1_p1;
   logic signed [CIC_W-1:0] l_d2_p1;
   logic signed [CIC_W-1:0] l_d3_p1;
   logic signed [CIC_W-1:0] r_d1_p1;
   logic signed [CIC_W-1:0] r_d2_p1;
   logic signed [CIC_W-1:0] r_d3_p1;
   logic signed [CIC_W-1:0] l_c1_p1;
   logic signed [CIC_W-1:0] l_c2_p1;
   logic signed [CIC_W-1:0] l_c3_p1;
   logic signed [CIC_W-1:0] r_c1_p1;
   logic signed [CIC_W-1:0] r_c2_p1;
   logic signed [CIC_W-1:0] r_c3_p1;

   logic                    vld_p2;
   logic                    ovr_p2;
   logic signed [CIC_W-1:0] pcm_l_p2;
   logic signed [CIC_W-1:0] pcm_r_p2;

   // Stage p0: input synchronizer, micclk edge detect, sample mapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pdm_m <= 1'b0;
         pdm_s <= 1'b0;
         mc_d  <= 1'b0;
      end else begin
         pdm_m <= pdm_data;
         pdm_s <= pdm_m;
         mc_d  <= micclk;
      end
   end

   assign rise      = micclk & ~mc_d;
   assign fall      = ~micclk & mc_d;
   assign x_p0      = pdm_to_x(pdm_s);
   assign strobe_p0 = rise & (dcnt == DCNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         dcnt <= '0;
      else if (!en)
         dcnt <= '0;
      else if (rise)
         dcnt <= dcnt + 1'b1;
   end

   // Integrator chains; each stage uses the previous value of the one before it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         l_i1_p0 <= '0;
         l_i2_p0 <= '0;
         l_i3_p0 <= '0;
      end else if (!en) begin
         l_i1_p0 <= '0;
         l_i2_p0 <= '0;
         l_i3_p0 <= '0;
      end else if (fall) begin
         l_i1_p0 <= l_i1_p0 + x_p0;
         l_i2_p0 <= l_i2_p0 + l_i1_p0;
         l_i3_p0 <= l_i3_p0 + l_i2_p0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_i1_p0 <= '0;
         r_i2_p0 <= '0;
         r_i3_p0 <= '0;
      end else if (!en) begin
         r_i1_p0 <= '0;
         r_i2_p0 <= '0;
         r_i3_p0 <= '0;
      end else if (rise) begin
         r_i1_p0 <= r_i1_p0 + x_p0;
         r_i2_p0 <= r_i2_p0 + r_i1_p0;
         r_i3_p0 <= r_i3_p0 + r_i2_p0;
      end
   end

   // Stage p1: frame strobe delayed one cycle so the strobing rise's R update is included
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= en & strobe_p0;
   end

   assign l_c1_p1 = l_i3_p0 - l_d1_p1;
   assign l_c2_p1 = l_c1_p1 - l_d2_p1;
   assign l_c3_p1 = l_c2_p1 - l_d3_p1;
   assign r_c1_p1 = r_i3_p0 - r_d1_p1;
   assign r_c2_p1 = r_c1_p1 - r_d2_p1;
   assign r_c3_p1 = r_c2_p1 - r_d3_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         l_d1_p1 <= '0;
         l_d2_p1 <= '0;
         l_d3_p1 <= '0;
         r_d1_p1 <= '0;
         r_d2_p1 <= '0;
         r_d3_p1 <= '0;
      end else if (!en) begin
         l_d1_p1 <= '0;
         l_d2_p1 <= '0;
         l_d3_p1 <= '0;
         r_d1_p1 <= '0;
         r_d2_p1 <= '0;
         r_d3_p1 <= '0;
      end else if (vld_p1) begin
         l_d1_p1 <= l_i3_p0;
         l_d2_p1 <= l_c1_p1;
         l_d3_p1 <= l_c2_p1;
         r_d1_p1 <= r_i3_p0;
         r_d2_p1 <= r_c1_p1;
         r_d3_p1 <= r_c2_p1;
      end
   end

   // Stage p2: output registers and handshake; pcm holds across en=0 and acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcm_l_p2 <= '0;
         pcm_r_p2 <= '0;
      end else if (en && vld_p1) begin
         pcm_l_p2 <= l_c3_p1;
         pcm_r_p2 <= r_c3_p1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p2 <= 1'b0;
         ovr_p2 <= 1'b0;
      end else if (!en) begin
         vld_p2 <= 1'b0;
         ovr_p2 <= 1'b0;
      end else if (vld_p1) begin
         vld_p2 <= 1'b1;
         if (vld_p2 && !out_ready)
            ovr_p2 <= 1'b1;
      end else if (vld_p2 && out_ready) begin
         vld_p2 <= 1'b0;
      end
   end

   assign pcm_left  = pcm_l_p2;
   assign pcm_right = pcm_r_p2;
   assign out_valid = vld_p2;
   assign overrun   = ovr_p2;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: full-scale, split, alternating patterns,
// latency, handshake, overrun, stuck micclk, en clear and asynchronous reset.
module tb_pdm_cic_decimator;

   localparam int LOG2_DEC = 5;
   localparam int CIC_W    = 17;
   localparam int M_CONST  = 0;
   localparam int M_PAIR   = 1;
   localparam int M_ALT    = 2;
   localparam int M_RAND   = 3;
   localparam logic [31:0] FS_POS = 32'h0000_8000;  // +32^3 in 17 bits
   localparam logic [31:0] FS_NEG = 32'h0001_8000;  // -32^3 in 17 bits

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             micclk;
   logic             pdm_data;
   logic [CIC_W-1:0] pcm_left;
   logic [CIC_W-1:0] pcm_right;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;

   int   n_cmp = 0;
   int   n_err = 0;
   int   pcnt  = 0;
   int   rises = 0;
   int   mode  = M_CONST;
   int   gap   = 0;
   bit   freeze = 1'b0;
   logic pdm_lvl = 1'b1;

   always #5 clk = ~clk;

   pdm_cic_decimator #(.LOG2_DEC(LOG2_DEC)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .micclk    (micclk),
      .pdm_data  (pdm_data),
      .pcm_left  (pcm_left),
      .pcm_right (pcm_right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clk: micclk toggles every 4 clk (period 8), inputs change on the falling clk edge
   task automatic step();
      @(negedge clk);
      if (!freeze) begin
         if (pcnt == 3) begin
            pcnt   = 0;
            micclk = ~micclk;
            if (micclk) begin
               rises++;
               if (mode == M_ALT)
                  pdm_lvl = ~pdm_lvl;
            end
         end else begin
            pcnt++;
         end
      end
      case (mode)
         M_CONST: pdm_data = pdm_lvl;
         M_PAIR:  pdm_data = micclk;
         M_ALT:   pdm_data = pdm_lvl;
         default: pdm_data = 1'($urandom);
      endcase
   endtask

   task automatic release_rst();
      int guard = 0;
      do begin
         step();
         guard++;
      end while ((micclk !== 1'b0 || pcnt != 0) && guard < 64);
      rst   = 1'b1;
      rises = 0;
   endtask

   task automatic first_frame(input string tag);
      int guard = 0;
      bit early = 1'b0;
      while (rises < 32 && guard < 400) begin
         step();
         guard++;
         if (out_valid !== 1'b0)
            early = 1'b1;
      end
      chk({tag, "_early"}, 32'(early), 32'd0);
      step();
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
   endtask

   task automatic wait_frame(output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (out_valid !== 1'b1 && cycles < 300);
      chk("frame_seen", 32'(out_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; out_ready = 1'b1; micclk = 1'b0; pdm_data = 1'b0;
      repeat (3) step();
      chk("rst_l",   32'(pcm_left),  32'd0);
      chk("rst_r",   32'(pcm_right), 32'd0);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_ovr", 32'(overrun),   32'd0);

      // Constant ones after reset: frame 1 after exactly 32 rises, frames 4+ at +32768
      release_rst();
      first_frame("rst0");
      repeat (2) wait_frame(gap);
      wait_frame(gap);
      chk("c1_gap", 32'(gap), 32'd256);
      chk("c1_l",   32'(pcm_left),  FS_POS);
      chk("c1_r",   32'(pcm_right), FS_POS);
      wait_frame(gap);
      chk("c1_l5",  32'(pcm_left),  FS_POS);

      // Constant zeros
      pdm_lvl = 1'b0;
      repeat (3) wait_frame(gap);
      wait_frame(gap);
      chk("c0_l", 32'(pcm_left),  FS_NEG);
      chk("c0_r", 32'(pcm_right), FS_NEG);

      // 1 while micclk high, 0 while low
      mode = M_PAIR;
      repeat (3) wait_frame(gap);
      wait_frame(gap);
      chk("pr_l", 32'(pcm_left),  FS_POS);
      chk("pr_r", 32'(pcm_right), FS_NEG);

      // Alternating bit per micclk period
      mode = M_ALT;
      repeat (3) wait_frame(gap);
      wait_frame(gap);
      chk("alt_l", 32'(pcm_left),  32'd0);
      chk("alt_r", 32'(pcm_right), 32'd0);
      wait_frame(gap);
      chk("alt_gap", 32'(gap), 32'd256);
      chk("alt_l2",  32'(pcm_left), 32'd0);

      // Frame held, then accepted in the cycle the next frame loads
      out_ready = 1'b0;
      repeat (255) step();
      chk("hs_hold", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step();
      chk("hs_load", 32'(out_valid), 32'd1);
      chk("hs_ovr",  32'(overrun),   32'd0);
      step();
      chk("hs_clr",  32'(out_valid), 32'd0);

      // Backpressure over several frames while switching to constant ones
      out_ready = 1'b0;
      mode      = M_CONST;
      pdm_lvl   = 1'b1;
      repeat (254) step();
      chk("ov_pre",   32'(out_valid), 32'd0);
      step();
      chk("ov_a_vld", 32'(out_valid), 32'd1);
      chk("ov_a_ovr", 32'(overrun),   32'd0);
      repeat (255) step();
      chk("ov_b_pre", 32'(overrun),   32'd0);
      step();
      chk("ov_b_ovr", 32'(overrun),   32'd1);
      chk("ov_b_vld", 32'(out_valid), 32'd1);
      repeat (512) step();
      chk("ov_d_l",   32'(pcm_left),  FS_POS);
      chk("ov_d_r",   32'(pcm_right), FS_POS);
      chk("ov_d_ovr", 32'(overrun),   32'd1);

      // micclk stuck: nothing moves
      freeze = 1'b1;
      repeat (600) step();
      chk("st_vld", 32'(out_valid), 32'd1);
      chk("st_ovr", 32'(overrun),   32'd1);
      chk("st_l",   32'(pcm_left),  FS_POS);
      freeze = 1'b0;

      // en low for one clk mid-frame
      step();
      en    = 1'b0;
      rises = 0;
      step();
      en = 1'b1;
      chk("en_vld", 32'(out_valid), 32'd0);
      chk("en_ovr", 32'(overrun),   32'd0);
      chk("en_pcm", 32'(pcm_left),  FS_POS);
      out_ready = 1'b1;
      first_frame("en");

      // Asynchronous reset mid-frame under random data
      mode      = M_RAND;
      out_ready = 1'b0;
      repeat (300) step();
      #2 rst = 1'b0;
      #1;
      chk("ar_l",   32'(pcm_left),  32'd0);
      chk("ar_r",   32'(pcm_right), 32'd0);
      chk("ar_vld", 32'(out_valid), 32'd0);
      chk("ar_ovr", 32'(overrun),   32'd0);
      repeat (4) step();
      release_rst();
      out_ready = 1'b1;
      first_frame("ar");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
